// File: rtl/spell_dbg_port_if.sv
// Host-side command/response channels of the SPELL debug port.
// Both channels: a transfer happens on a rising clk edge where valid && ready; the source holds payload stable while valid && !ready.
interface spell_dbg_port_if #(
   parameter int DATA_W = 8
);
   logic              i_cmd_valid;
   logic              o_cmd_ready;
   logic [1:0]        i_cmd;
   logic [1:0]        i_cmd_reg;
   logic [DATA_W-1:0] i_cmd_data;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DATA_W-1:0] o_rsp_data;

   modport master (
      output i_cmd_valid, i_cmd, i_cmd_reg, i_cmd_data, i_rsp_ready,
      input  o_cmd_ready, o_rsp_valid, o_rsp_data
   );

   modport slave (
      input  i_cmd_valid, i_cmd, i_cmd_reg, i_cmd_data, i_rsp_ready,
      output o_cmd_ready, o_rsp_valid, o_rsp_data
   );
endinterface

// File: rtl/spell_dbg_port.sv
// Debug port controller: turns one host command into SPELL run/step/shift strobes
// and returns one response byte. All outputs are registered.
module spell_dbg_port #(
   parameter int DATA_W       = 8,
   parameter int STEP_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   spell_dbg_port_if.slave      host,
   output logic                 o_run,
   output logic                 o_step,
   output logic                 o_load,
   output logic                 o_dump,
   output logic                 o_shift_in,
   output logic [1:0]           o_reg_sel,
   input  logic                 i_shift_out,
   input  logic                 i_cpu_stop,
   input  logic                 i_cpu_sleep,
   output logic [2:0]           o_dbg_state
);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WR         = 3'd1;
   localparam logic [2:0] S_RD         = 3'd2;
   localparam logic [2:0] S_STEP_PULSE = 3'd3;
   localparam logic [2:0] S_STEP_WAIT  = 3'd4;
   localparam logic [2:0] S_RESP       = 3'd5;

   localparam int CW = $clog2(DATA_W + 1);

   logic [2:0]        state;
   logic [CW-1:0]     cnt;
   logic [15:0]       wcnt;
   logic [DATA_W-1:0] shreg;

   assign o_dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         cnt              <= '0;
         wcnt             <= '0;
         shreg            <= '0;
         host.o_cmd_ready <= 1'b1;
         host.o_rsp_valid <= 1'b0;
         host.o_rsp_data  <= '0;
         o_run            <= 1'b0;
         o_step           <= 1'b0;
         o_load           <= 1'b0;
         o_dump           <= 1'b0;
         o_shift_in       <= 1'b0;
         o_reg_sel        <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (host.i_cmd_valid) begin
                  host.o_cmd_ready <= 1'b0;
                  o_reg_sel        <= host.i_cmd_reg;
                  cnt              <= '0;
                  wcnt             <= '0;
                  if (host.i_cmd == 2'b11) begin
                     o_run            <= host.i_cmd_data[0];
                     host.o_rsp_data  <= '0;
                     host.o_rsp_valid <= 1'b1;
                     state            <= S_RESP;
                  end else if (o_run) begin
                     // The core is free-running: refuse to touch its registers.
                     host.o_rsp_data  <= '1;
                     host.o_rsp_valid <= 1'b1;
                     state            <= S_RESP;
                  end else if (host.i_cmd == 2'b00) begin
                     o_load     <= 1'b1;
                     o_shift_in <= host.i_cmd_data[DATA_W-1];
                     shreg      <= {host.i_cmd_data[DATA_W-2:0], 1'b0};
                     state      <= S_WR;
                  end else if (host.i_cmd == 2'b01) begin
                     o_dump <= 1'b1;
                     shreg  <= '0;
                     state  <= S_RD;
                  end else begin
                     o_step <= 1'b1;
                     state  <= S_STEP_PULSE;
                  end
               end
            end
            S_WR: begin
               if (cnt == CW'(DATA_W - 1)) begin
                  o_load           <= 1'b0;
                  o_shift_in       <= 1'b0;
                  host.o_rsp_data  <= '0;
                  host.o_rsp_valid <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  cnt        <= cnt + 1'b1;
                  o_shift_in <= shreg[DATA_W-1];
                  shreg      <= {shreg[DATA_W-2:0], 1'b0};
               end
            end
            S_RD: begin
               // The core answers one cycle behind each dump strobe, so the
               // sample window is shifted one cycle later than the dump window.
               if (cnt == CW'(DATA_W - 1)) o_dump <= 1'b0;
               if (cnt != '0) shreg <= {shreg[DATA_W-2:0], i_shift_out};
               if (cnt == CW'(DATA_W)) begin
                  host.o_rsp_data  <= {shreg[DATA_W-2:0], i_shift_out};
                  host.o_rsp_valid <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STEP_PULSE: begin
               o_step <= 1'b0;
               state  <= S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
               if (i_cpu_stop) begin
                  host.o_rsp_data  <= {{(DATA_W-2){1'b0}}, 1'b0, i_cpu_sleep};
                  host.o_rsp_valid <= 1'b1;
                  state            <= S_RESP;
               end else if (wcnt == 16'(STEP_TIMEOUT - 1)) begin
                  host.o_rsp_data  <= {{(DATA_W-2){1'b0}}, 1'b1, i_cpu_sleep};
                  host.o_rsp_valid <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_RESP: begin
               if (host.i_rsp_ready) begin
                  host.o_rsp_valid <= 1'b0;
                  host.o_cmd_ready <= 1'b1;
                  state            <= S_IDLE;
               end
            end
            default: begin
               state            <= S_IDLE;
               host.o_cmd_ready <= 1'b1;
               host.o_rsp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spell_dbg_port.sv
// Bench for spell_dbg_port: directed and random commands against a command-level
// model, with a scoreboard monitor and a small serial CPU register model.
module tb_spell_dbg_port;
   localparam int DATA_W = 8;
   localparam int TMO    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spell_dbg_port_if #(.DATA_W(DATA_W)) hif();

   logic       o_run, o_step, o_load, o_dump, o_shift_in;
   logic [1:0] o_reg_sel;
   logic       i_shift_out;
   logic       i_cpu_stop;
   logic       i_cpu_sleep = 1'b0;
   logic [2:0] dbg_state;

   spell_dbg_port #(.DATA_W(DATA_W), .STEP_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .host(hif),
      .o_run(o_run), .o_step(o_step), .o_load(o_load), .o_dump(o_dump),
      .o_shift_in(o_shift_in), .o_reg_sel(o_reg_sel), .i_shift_out(i_shift_out),
      .i_cpu_stop(i_cpu_stop), .i_cpu_sleep(i_cpu_sleep), .o_dbg_state(dbg_state)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int acc_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- CPU model: serial register file, stop 3 cycles after step
   logic [DATA_W-1:0] cpu_regs[4] = '{8'h11, 8'h3C, 8'h5A, 8'hC3};
   logic [DATA_W-1:0] load_bits = '0;
   int  load_total = 0, dump_total = 0, step_total = 0;
   int  dump_idx = 0, stop_cnt = 0;
   bit  stop_en = 1'b0;

   initial i_shift_out = 1'b0;
   always @(posedge clk) begin
      if (o_load) begin
         cpu_regs[o_reg_sel] <= {cpu_regs[o_reg_sel][DATA_W-2:0], o_shift_in};
         load_bits           <= {load_bits[DATA_W-2:0], o_shift_in};
         load_total          <= load_total + 1;
      end
      if (o_dump) begin
         if (dump_idx < DATA_W) i_shift_out <= cpu_regs[o_reg_sel][DATA_W-1-dump_idx];
         dump_idx   <= dump_idx + 1;
         dump_total <= dump_total + 1;
      end else begin
         dump_idx    <= 0;
         i_shift_out <= 1'b0;
      end
      if (o_step) begin
         stop_cnt   <= 1;
         step_total <= step_total + 1;
      end else if (stop_cnt != 0 && stop_cnt < 8) begin
         stop_cnt <= stop_cnt + 1;
      end else begin
         stop_cnt <= 0;
      end
   end
   assign i_cpu_stop = stop_en && (stop_cnt == 3);

   // ---------------- reference model and scoreboard
   logic [DATA_W-1:0] model_regs[4] = '{8'h11, 8'h3C, 8'h5A, 8'hC3};
   bit model_run = 1'b0;
   logic [DATA_W-1:0] exp_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (!o_load) chk("shift_in_idle", {31'd0, o_shift_in}, 32'd0);
         if (hif.o_rsp_valid) begin
            chk("busy_ready", {31'd0, hif.o_cmd_ready}, 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_rsp: got %0h expected none", hif.o_rsp_data);
            end else if (hif.i_rsp_ready) begin
               chk("rsp_data", {24'd0, hif.o_rsp_data}, {24'd0, exp_q.pop_front()});
            end else begin
               chk("rsp_hold", {24'd0, hif.o_rsp_data}, {24'd0, exp_q[0]});
            end
         end
      end
   end

   // ---------------- driver
   task automatic send(input logic [1:0] op, input logic [1:0] rg,
                       input logic [DATA_W-1:0] d, input bit junk);
      int b = 0;
      while (!hif.o_cmd_ready && b < 100) begin
         @(posedge clk); #1;
         b++;
      end
      chk("cmd_ready_wait", {31'd0, hif.o_cmd_ready}, 32'd1);
      hif.i_cmd_valid = 1'b1;
      hif.i_cmd       = op;
      hif.i_cmd_reg   = rg;
      hif.i_cmd_data  = d;
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (junk) begin
         hif.i_cmd      = 2'($urandom_range(0, 3));
         hif.i_cmd_reg  = 2'($urandom_range(0, 3));
         hif.i_cmd_data = DATA_W'($urandom_range(0, 255));
      end else begin
         hif.i_cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_rsp(input int stall, input int lat);
      int first = -1;
      int held  = 0;
      for (int c = 0; c < 400; c++) begin
         if (hif.o_rsp_valid) begin
            if (first < 0) first = cyc - acc_cyc + 1;
            if (held >= stall) begin
               hif.i_cmd_valid = 1'b0;
               hif.i_rsp_ready = 1'b1;
               @(posedge clk); #1;
               hif.i_rsp_ready = 1'b0;
               break;
            end
            held++;
         end
         @(posedge clk); #1;
      end
      hif.i_cmd_valid = 1'b0;
      chk("rsp_latency", first, lat);
      chk("ready_after_rsp", {31'd0, hif.o_cmd_ready}, 32'd1);
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [1:0] rg, input logic [DATA_W-1:0] d,
                         input bit slp, input bit sen, input int stall, input bit junk);
      logic [DATA_W-1:0] exp;
      int lat;
      int l0, d0, s0;
      l0 = load_total; d0 = dump_total; s0 = step_total;
      i_cpu_sleep = slp;
      stop_en     = sen;
      if (op != 2'b11 && model_run) begin
         exp = '1; lat = 1;
      end else begin
         case (op)
            2'b00: begin model_regs[rg] = d; exp = '0; lat = DATA_W + 1; end
            2'b01: begin exp = model_regs[rg]; lat = DATA_W + 2; end
            2'b10: begin
               exp = sen ? DATA_W'(slp) : DATA_W'(2 + slp);
               lat = sen ? 5 : 2 + TMO;
            end
            default: begin model_run = d[0]; exp = '0; lat = 1; end
         endcase
      end
      exp_q.push_back(exp);
      send(op, rg, d, junk);
      wait_rsp(stall, lat);
      chk("run_level", {31'd0, o_run}, {31'd0, model_run});
      chk("reg_sel", {30'd0, o_reg_sel}, {30'd0, rg});
      chk("load_cycles", load_total - l0, (op == 2'b00 && exp == 0) ? DATA_W : 0);
      chk("dump_cycles", dump_total - d0, (op == 2'b01 && exp != '1) ? DATA_W : 0);
      chk("step_pulses", step_total - s0, (op == 2'b10 && exp != '1) ? 1 : 0);
      stop_en = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_cmd_ready", {31'd0, hif.o_cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, hif.o_rsp_valid}, 32'd0);
      chk("rst_rsp_data",  {24'd0, hif.o_rsp_data}, 32'd0);
      chk("rst_strobes", {27'd0, o_run, o_step, o_load, o_dump, o_shift_in}, 32'd0);
      chk("rst_reg_sel", {30'd0, o_reg_sel}, 32'd0);
   endtask

   initial begin
      int cnt;
      hif.i_cmd_valid = 1'b1;
      hif.i_cmd       = 2'b00;
      hif.i_cmd_reg   = 2'd3;
      hif.i_cmd_data  = 8'hFF;
      hif.i_rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk_reset_vals();
      end
      hif.i_cmd_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("no_accept_in_reset", {31'd0, o_load}, 32'd0);
      chk_reset_vals();

      // write 0xA5 to reg 2, MSB first on the shift line
      do_cmd(2'b00, 2'd2, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
      chk("wr_bits", {24'd0, load_bits}, 32'hA5);
      do_cmd(2'b01, 2'd1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b01, 2'd2, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b01, 2'd1, 8'h00, 1'b0, 1'b0, 5, 1'b1);

      // step: stop seen, timeout, stop while sleeping
      do_cmd(2'b10, 2'd0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
      do_cmd(2'b10, 2'd0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b10, 2'd3, 8'h00, 1'b1, 1'b1, 2, 1'b0);

      // run guard
      do_cmd(2'b11, 2'd0, 8'h01, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b00, 2'd1, 8'h77, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b01, 2'd1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      do_cmd(2'b10, 2'd1, 8'h00, 1'b0, 1'b1, 0, 1'b0);
      do_cmd(2'b11, 2'd0, 8'h00, 1'b0, 1'b0, 0, 1'b0);

      // reset during the 4th dump cycle of a read
      send(2'b01, 2'd3, 8'h00, 1'b0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_dump) cnt++;
         if (cnt == 4) break;
         @(posedge clk); #1;
      end
      chk("mid_rd_dump_seen", cnt, 4);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rd_dump_off", {31'd0, o_dump}, 32'd0);
      chk_reset_vals();
      rst = 1'b0;
      model_run = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      chk("mid_rd_ready", {31'd0, hif.o_cmd_ready}, 32'd1);
      chk("mid_rd_no_rsp", {31'd0, hif.o_rsp_valid}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         if (op == 2'b11 && $urandom_range(0, 2) != 0) op = 2'($urandom_range(0, 2));
         do_cmd(op, 2'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      repeat (4) begin @(posedge clk); #1; end
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/spell_dbg_port.md
# spell_dbg_port

Host-side debug port controller that sits directly upstream of the SPELL CPU core's run/step/register-shift control interface. It accepts one 8-bit debug command at a time over a valid/ready handshake and sequences the CPU-side control strobes for each command. The supported commands are register write, register read, single-step and run/halt. For each command it returns one response byte over a second valid/ready handshake.

## Interface
Parameters:
- DATA_W, 8, width of a CPU register (bits shifted per read/write)
- STEP_TIMEOUT, 255, max cycles to wait for i_cpu_stop after a step pulse (1..65535)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_cmd_valid  input  1  command valid
- o_cmd_ready  output  1  command accepted when valid&&ready
- i_cmd  input  2  opcode: 00 write reg, 01 read reg, 10 step, 11 run/halt
- i_cmd_reg  input  2  target register select
- i_cmd_data  input  DATA_W  write data; bit 0 = run level for opcode 11
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response consumed when valid&&ready
- o_rsp_data  output  DATA_W  response byte
- o_run  output  1  CPU run level
- o_step  output  1  CPU single-step pulse
- o_load  output  1  CPU shift-in enable
- o_dump  output  1  CPU shift-out enable
- o_shift_in  output  1  serial write data to CPU
- o_reg_sel  output  2  CPU register select
- i_shift_out  input  1  serial read data from CPU
- i_cpu_stop  input  1  CPU stopped
- i_cpu_sleep  input  1  CPU sleeping

## Operation
- States: IDLE, WR, RD, STEP_PULSE, STEP_WAIT, RESP.
- IDLE: o_cmd_ready=1. On accept, latch opcode, reg and data, drive o_reg_sel=i_cmd_reg, then branch by opcode.
- WR (opcode 00): o_load=1 for exactly DATA_W cycles. o_shift_in carries data MSB first (bit DATA_W-1 in the first load cycle). Response is 0x00.
- RD (opcode 01): o_dump=1 for exactly DATA_W cycles. The CPU presents register bits MSB first on i_shift_out, each one cycle after the matching dump cycle. The block samples i_shift_out on the DATA_W cycles following the first dump cycle and shifts each sample into the response at the LSB. Response is the register value.
- STEP (opcode 10): o_step=1 for exactly one cycle (STEP_PULSE), then STEP_WAIT.
  - STEP_WAIT ends when i_cpu_stop=1 or after STEP_TIMEOUT cycles.
  - Response is {zeros, timeout, i_cpu_sleep sampled at exit}.
- RUN (opcode 11): o_run takes i_cmd_data[0] on the cycle after accept, then RESP with 0x00. o_run holds that level until the next opcode 11 or reset.
- Error case: opcode 00/01/10 accepted while o_run=1 issues no strobes and goes straight to RESP with 0xFF.
- RESP: o_rsp_valid=1 and o_rsp_data stable until i_rsp_ready=1. On the handshake cycle, return to IDLE.
- o_reg_sel holds its value from accept through RESP, and keeps its last value while in IDLE.
- o_shift_in=0 whenever o_load=0.

## Timing
- Reset values: o_cmd_ready=1, o_rsp_valid=0, o_rsp_data=0, o_run=0, o_step=0, o_load=0, o_dump=0, o_shift_in=0, o_reg_sel=0.
- All outputs are registered. Accept at edge N means the first strobe appears in cycle N+1.
- Write: o_load high in cycles N+1..N+DATA_W; o_rsp_valid in cycle N+DATA_W+1.
- Read: o_dump high in cycles N+1..N+DATA_W; sampling in N+2..N+DATA_W+1; o_rsp_valid in cycle N+DATA_W+2.
- Step: o_step in N+1; stop sampled from N+2; o_rsp_valid the cycle after stop is seen or after timeout.
- Run: o_run updates in N+1; o_rsp_valid in N+1.
- Error: o_rsp_valid in N+1.
- o_cmd_ready=0 from the cycle after accept until the cycle after the response handshake. Back-to-back commands therefore have at least one idle cycle between them.
- i_cmd_valid while busy is ignored; the command is not latched.
- rst asserted in any state forces reset values at the next edge and drops strobes mid-shift; no response is produced.
- A response stall (i_rsp_ready=0) holds RESP indefinitely with no strobe activity.

## Test plan
- Reset: hold rst 2 cycles with i_cmd_valid=1 -> all outputs at reset values; no accept during reset.
- Write: cmd=00, reg=2, data=0xA5 -> o_reg_sel=2; o_load high 8 cycles; o_shift_in sequence 1,0,1,0,0,1,0,1; response 0x00.
- Read: cmd=01, reg=1, CPU model returns 0x3C -> o_dump high 8 cycles; response 0x3C. Repeat with i_rsp_ready held low 5 cycles -> data stable and o_cmd_ready=0 throughout.
- Step: CPU model raises i_cpu_stop 3 cycles after o_step -> response 0x00. Repeat with i_cpu_stop never raised and STEP_TIMEOUT=4 -> response 0x02 after 4 wait cycles.
- Run guard: cmd=11 data=1 -> o_run=1, response 0x00. Then cmd=00 -> no o_load, response 0xFF. Then cmd=11 data=0 -> o_run=0.
- Reset mid-read: assert rst in the 4th dump cycle -> o_dump=0 next cycle, no o_rsp_valid, o_cmd_ready=1 after release.
